cr16_ctrl_hs: RTL

Parametrised multicycle control unit for the 16-bit CR16-style datapath. It adds a variable-latency memory handshake, a bounded memory timeout, and a single shared condition evaluator used by both Jcond and Bcond. It latches the instruction internally and drives register-file, ALU, writeback-mux, memory and PC-select controls. It sits between the instruction/data memory port and the datapath.

---
 rtl/cr16_ctrl_hs.sv | 317 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/cr16_ctrl_hs.sv
// cr16_ctrl_hs: multicycle control unit for a 16-bit CR16-style datapath.
// Sequence is FETCH -> DECODE -> EXEC, or FETCH -> DECODE -> MEM for loads/stores.
// Memory requests stay asserted until mem_ack arrives or a bounded timeout aborts them.
// Jcond and Bcond share one condition evaluator that samples the live flag inputs in EXEC.
// R-type ext codes match the ALU codes: ADD 1000, SUB 0001, CMP 0010, AND 0011,
// OR 0100, XOR 0101, and MOV 0000.
// Optional feature macro: CR16_CTRL_TRAP_ILLEGAL_EN. When it is defined, an illegal
// encoding parks the unit in TRAP and adds a trap output port.
module cr16_ctrl_hs #(
  parameter int ALU_W       = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      instr,
  input  logic [4:0]       flags,
  input  logic             mem_ack,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             src_en,
  output logic             dst_en,
  output logic             imm_en,
  output logic             imm_sign,
  output logic [ALU_W-1:0] alu_op,
  output logic             alu_b_imm,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             flags_we,
  output logic [1:0]       pc_sel,
  output logic             retire,
  output logic             mem_err
`ifdef CR16_CTRL_TRAP_ILLEGAL_EN
  ,
  output logic             trap
`endif
);

  localparam logic [ALU_W-1:0] ALU_PASS = ALU_W'(4'b0000);
  localparam logic [ALU_W-1:0] ALU_ADD  = ALU_W'(4'b1000);
  localparam logic [ALU_W-1:0] ALU_SUB  = ALU_W'(4'b0001);
  localparam logic [ALU_W-1:0] ALU_CMP  = ALU_W'(4'b0010);
  localparam logic [ALU_W-1:0] ALU_AND  = ALU_W'(4'b0011);
  localparam logic [ALU_W-1:0] ALU_OR   = ALU_W'(4'b0100);
  localparam logic [ALU_W-1:0] ALU_XOR  = ALU_W'(4'b0101);
  localparam logic [ALU_W-1:0] ALU_LUI  = ALU_W'(4'b0110);
  localparam logic [ALU_W-1:0] ALU_LSH  = ALU_W'(4'b0111);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_TRAP
  } state_t;

  state_t          state;
  logic [15:0]     ir;
  logic [TO_W-1:0] wait_cnt;

  logic [3:0] op;
  logic [3:0] cond;
  logic [3:0] ext;
  logic       rs_unused;

  assign op        = ir[15:12];
  assign cond      = ir[11:8];
  assign ext       = ir[7:4];
  // The rs field goes straight to the datapath register file, so the control unit never reads it.
  assign rs_unused = ^ir[3:0];

  logic             dec_reg;
  logic             dec_imm;
  logic             dec_load;
  logic             dec_stor;
  logic             dec_jal;
  logic             dec_jcond;
  logic             dec_bcond;
  logic             dec_lsh;
  logic             dec_lshi;
  logic             dec_sign;
  logic             dec_fwe;
  logic             dec_cmp;
  logic             dec_mov;
  logic             dec_alu;
  logic             dec_legal;
  logic [ALU_W-1:0] dec_alu_op;

  logic waiting;
  logic timeout;
  logic cond_ok;

  // Evaluates the shared Jcond/Bcond condition code against {C,L,F,Z,N}.
  function automatic logic cond_true(input logic [3:0] c, input logic [4:0] f);
    logic fc, fl, ff, fz, fn;
    fc = f[4];
    fl = f[3];
    ff = f[2];
    fz = f[1];
    fn = f[0];
    case (c)
      4'b0000: cond_true = fz;
      4'b0001: cond_true = !fz;
      4'b0010: cond_true = fc;
      4'b0011: cond_true = !fc;
      4'b0100: cond_true = fl;
      4'b0101: cond_true = !fl;
      4'b0110: cond_true = fn;
      4'b0111: cond_true = !fn;
      4'b1000: cond_true = ff;
      4'b1001: cond_true = !ff;
      4'b1010: cond_true = !fl && !fz;
      4'b1011: cond_true = fl || fz;
      4'b1100: cond_true = !fn && !fz;
      4'b1101: cond_true = fn || fz;
      4'b1110: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  endfunction

  assign cond_ok = cond_true(cond, flags);

  // A request is outstanding in FETCH and MEM. It aborts on the last counted cycle unless ack arrives in that same cycle.
  assign waiting = (state == S_FETCH) || (state == S_MEM);
  assign timeout = waiting && !mem_ack && (wait_cnt == TO_LAST);

  // Classify the latched instruction into its instruction family and ALU behaviour.
  always_comb begin
    dec_reg    = 1'b0;
    dec_imm    = 1'b0;
    dec_load   = 1'b0;
    dec_stor   = 1'b0;
    dec_jal    = 1'b0;
    dec_jcond  = 1'b0;
    dec_bcond  = 1'b0;
    dec_lsh    = 1'b0;
    dec_lshi   = 1'b0;
    dec_sign   = 1'b0;
    dec_fwe    = 1'b0;
    dec_cmp    = 1'b0;
    dec_mov    = 1'b0;
    dec_alu_op = ALU_PASS;
    case (op)
      4'b0000: begin
        dec_reg = 1'b1;
        case (ext)
          4'b1000: begin dec_alu_op = ALU_ADD; dec_fwe = 1'b1; end
          4'b0001: begin dec_alu_op = ALU_SUB; dec_fwe = 1'b1; end
          4'b0010: begin dec_alu_op = ALU_CMP; dec_fwe = 1'b1; dec_cmp = 1'b1; end
          4'b0011: dec_alu_op = ALU_AND;
          4'b0100: dec_alu_op = ALU_OR;
          4'b0101: dec_alu_op = ALU_XOR;
          4'b0000: dec_mov = 1'b1;
          default: dec_reg = 1'b0;
        endcase
      end
      4'b0001: begin dec_imm = 1'b1; dec_alu_op = ALU_AND; end
      4'b0010: begin dec_imm = 1'b1; dec_alu_op = ALU_OR; end
      4'b0011: begin dec_imm = 1'b1; dec_alu_op = ALU_XOR; end
      4'b0101: begin
        dec_imm = 1'b1; dec_sign = 1'b1; dec_fwe = 1'b1; dec_alu_op = ALU_ADD;
      end
      4'b1001: begin
        dec_imm = 1'b1; dec_sign = 1'b1; dec_fwe = 1'b1; dec_alu_op = ALU_SUB;
      end
      4'b1011: begin
        dec_imm = 1'b1; dec_sign = 1'b1; dec_fwe = 1'b1; dec_cmp = 1'b1;
        dec_alu_op = ALU_CMP;
      end
      4'b1101: begin dec_imm = 1'b1; dec_sign = 1'b1; dec_mov = 1'b1; end
      4'b1111: begin dec_imm = 1'b1; dec_alu_op = ALU_LUI; end
      4'b0100: begin
        case (ext)
          4'b0000: dec_load  = 1'b1;
          4'b0100: dec_stor  = 1'b1;
          4'b1000: dec_jal   = 1'b1;
          4'b1100: dec_jcond = 1'b1;
          default: ;
        endcase
      end
      4'b1000: begin
        if (ext == 4'b0100) begin
          dec_lsh    = 1'b1;
          dec_alu_op = ALU_LSH;
        end else if (ext[3:1] == 3'b000) begin
          dec_lshi   = 1'b1;
          dec_alu_op = ALU_LSH;
        end
      end
      4'b1100: dec_bcond = 1'b1;
      default: ;
    endcase
  end

  assign dec_alu   = dec_reg | dec_imm | dec_lsh | dec_lshi;
  assign dec_legal = dec_alu | dec_load | dec_stor | dec_jal | dec_jcond | dec_bcond;

  // Advance the state, latch the fetched instruction and run the request timeout counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_FETCH;
      ir       <= 16'h0000;
      wait_cnt <= '0;
    end else begin
      if (waiting && !mem_ack && !timeout) begin
        wait_cnt <= wait_cnt + TO_W'(1);
      end else begin
        wait_cnt <= '0;
      end
      case (state)
        S_FETCH: begin
          if (mem_ack) begin
            ir    <= instr;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (dec_load || dec_stor) begin
            state <= S_MEM;
`ifdef CR16_CTRL_TRAP_ILLEGAL_EN
          end else if (!dec_legal) begin
            state <= S_TRAP;
`endif
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: state <= S_FETCH;
        S_MEM: begin
          if (mem_ack || timeout) begin
            state <= S_FETCH;
          end
        end
        S_TRAP: state <= S_TRAP;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Drive the datapath controls from the current state. All outputs are forced low while reset is held.
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    src_en    = 1'b0;
    dst_en    = 1'b0;
    imm_en    = 1'b0;
    imm_sign  = 1'b0;
    alu_op    = ALU_PASS;
    alu_b_imm = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = 2'b00;
    flags_we  = 1'b0;
    pc_sel    = 2'b00;
    retire    = 1'b0;
    mem_err   = 1'b0;
`ifdef CR16_CTRL_TRAP_ILLEGAL_EN
    trap      = 1'b0;
`endif
    if (reset) begin
      case (state)
        S_FETCH: begin
          mem_rd  = 1'b1;
          mem_err = timeout;
        end
        S_DECODE: begin
          src_en   = dec_reg | dec_lsh | dec_load | dec_stor | dec_jal | dec_jcond;
          dst_en   = dec_reg | dec_lsh | dec_load | dec_stor | dec_jal | dec_jcond |
                     dec_imm | dec_lshi;
          imm_en   = dec_imm | dec_lshi;
          imm_sign = dec_sign;
        end
        S_EXEC: begin
          retire = 1'b1;
          pc_sel = 2'b01;
          if (dec_alu) begin
            alu_op    = dec_alu_op;
            alu_b_imm = dec_imm | dec_lshi;
            rf_we     = !dec_cmp;
            flags_we  = dec_fwe;
            wb_sel    = dec_mov ? 2'b10 : 2'b00;
          end else if (dec_jal) begin
            rf_we  = 1'b1;
            wb_sel = 2'b11;
            pc_sel = 2'b10;
          end else if (dec_jcond) begin
            pc_sel = cond_ok ? 2'b10 : 2'b01;
          end else if (dec_bcond) begin
            pc_sel = cond_ok ? 2'b11 : 2'b01;
          end
        end
        S_MEM: begin
          mem_rd = dec_load;
          mem_wr = dec_stor;
          if (mem_ack) begin
            rf_we  = dec_load;
            wb_sel = dec_load ? 2'b01 : 2'b00;
            pc_sel = 2'b01;
            retire = 1'b1;
          end else if (timeout) begin
            mem_err = 1'b1;
            pc_sel  = 2'b01;
            retire  = 1'b1;
          end
        end
        S_TRAP: begin
`ifdef CR16_CTRL_TRAP_ILLEGAL_EN
          trap = 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
